// File: rtl/mips_cpu_bus_pkg.sv
// rtl/mips_cpu_bus_pkg.sv - shared types and helpers for the CPU bus initiator
package mips_cpu_bus_pkg;

    localparam int MAX_READ_LATENCY = 3;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        BUS  = 3'd1,
        LAT  = 3'd2,
        RESP = 3'd3,
        ERR  = 3'd4
    } init_state_t;

    // The core encodes 2'b11 as a word access as well.
    function automatic size_t decode_size(input logic [1:0] raw);
        case (raw)
            2'd0:    decode_size = SZ_BYTE;
            2'd1:    decode_size = SZ_HALF;
            default: decode_size = SZ_WORD;
        endcase
    endfunction

    function automatic logic [3:0] be_gen(input size_t size, input logic [1:0] offset);
        case (size)
            SZ_BYTE: be_gen = 4'b0001 << offset;
            SZ_HALF: be_gen = offset[1] ? 4'b1100 : 4'b0011;
            default: be_gen = 4'b1111;
        endcase
    endfunction

    function automatic logic is_misaligned(input size_t size, input logic [1:0] offset);
        case (size)
            SZ_BYTE: is_misaligned = 1'b0;
            SZ_HALF: is_misaligned = offset[0];
            default: is_misaligned = |offset;
        endcase
    endfunction

endpackage

// File: rtl/mips_cpu_bus_lane_align.sv
// rtl/mips_cpu_bus_lane_align.sv - byte-lane steering for stores and extension for loads
module mips_cpu_bus_lane_align
    import mips_cpu_bus_pkg::*;
(
    input  size_t       size,
    input  logic [1:0]  offset,
    input  logic        is_signed,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  byteenable,
    output logic [31:0] wdata_lanes,
    output logic [31:0] rdata_ext
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        byteenable  = be_gen(size, offset);
        rd_byte     = rdata[{offset, 3'b000} +: 8];
        rd_half     = offset[1] ? rdata[31:16] : rdata[15:0];
        wdata_lanes = wdata;
        rdata_ext   = rdata;
        case (size)
            SZ_BYTE: begin
                wdata_lanes = {4{wdata[7:0]}};
                rdata_ext   = {{24{is_signed & rd_byte[7]}}, rd_byte};
            end
            SZ_HALF: begin
                wdata_lanes = {2{wdata[15:0]}};
                rdata_ext   = {{16{is_signed & rd_half[15]}}, rd_half};
            end
            default: begin
                wdata_lanes = wdata;
                rdata_ext   = rdata;
            end
        endcase
    end

endmodule

// File: rtl/mips_cpu_bus_initiator.sv
// rtl/mips_cpu_bus_initiator.sv - single-outstanding Avalon-MM style initiator for the CPU core
module mips_cpu_bus_initiator #(
    parameter int ADDR_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] address,
    output logic              read,
    output logic              write,
    output logic [3:0]        byteenable,
    output logic [31:0]       writedata,
    input  logic              waitrequest,
    input  logic [31:0]       readdata
);
    import mips_cpu_bus_pkg::*;

    localparam int LCW = $clog2(MAX_READ_LATENCY + 1);
    localparam logic [LCW-1:0] LAT_INIT = LCW'(READ_LATENCY > 0 ? READ_LATENCY - 1 : 0);

    init_state_t    state;
    size_t          size_q;
    logic [1:0]     off_q;
    logic           sgn_q;
    logic [LCW-1:0] lat_cnt;

    size_t       cur_size;
    logic [1:0]  cur_off;
    logic        req_mis;
    logic [3:0]  la_be;
    logic [31:0] la_wdata;
    logic [31:0] la_rdata;

    assign req_ready = (state == IDLE);

    // One lane aligner serves both directions: live request fields while idle
    // (store steering), captured fields once a load is in flight (extraction).
    assign cur_size = (state == IDLE) ? decode_size(req_size) : size_q;
    assign cur_off  = (state == IDLE) ? req_addr[1:0] : off_q;
    assign req_mis  = is_misaligned(decode_size(req_size), req_addr[1:0]);

    mips_cpu_bus_lane_align u_lane_align (
        .size        (cur_size),
        .offset      (cur_off),
        .is_signed   (sgn_q),
        .wdata       (req_wdata),
        .rdata       (readdata),
        .byteenable  (la_be),
        .wdata_lanes (la_wdata),
        .rdata_ext   (la_rdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            size_q     <= SZ_BYTE;
            off_q      <= 2'd0;
            sgn_q      <= 1'b0;
            lat_cnt    <= '0;
            address    <= '0;
            read       <= 1'b0;
            write      <= 1'b0;
            byteenable <= 4'd0;
            writedata  <= 32'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        size_q <= decode_size(req_size);
                        off_q  <= req_addr[1:0];
                        sgn_q  <= req_signed;
                        if (req_mis) begin
                            state      <= ERR;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'd0;
                        end else begin
                            state      <= BUS;
                            address    <= {req_addr[ADDR_W-1:2], 2'b00};
                            read       <= !req_write;
                            write      <= req_write;
                            byteenable <= la_be;
                            writedata  <= la_wdata;
                        end
                    end
                end
                BUS: begin
                    if (!waitrequest) begin
                        read  <= 1'b0;
                        write <= 1'b0;
                        if (write) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= 32'd0;
                        end else if (READ_LATENCY == 0) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= la_rdata;
                        end else begin
                            state   <= LAT;
                            lat_cnt <= LAT_INIT;
                        end
                    end
                end
                LAT: begin
                    if (lat_cnt == '0) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= la_rdata;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                RESP:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_bus_initiator.sv
// tb/tb_mips_cpu_bus_initiator.sv - bench for the CPU bus initiator at read latencies 0, 1 and 3
module tb_mips_cpu_bus_initiator;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid   [3];
    logic        waitrequest [3];
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] readdata;

    logic        req_ready  [3];
    logic        resp_valid [3];
    logic [31:0] resp_rdata [3];
    logic        resp_err   [3];
    logic [31:0] address    [3];
    logic        read       [3];
    logic        write      [3];
    logic [3:0]  byteenable [3];
    logic [31:0] writedata  [3];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mips_cpu_bus_initiator #(
            .ADDR_W       (32),
            .READ_LATENCY (g == 0 ? 0 : (g == 1 ? 1 : 3))
        ) dut (
            .clk         (clk),
            .reset_n     (reset_n),
            .req_valid   (req_valid[g]),
            .req_ready   (req_ready[g]),
            .req_write   (req_write),
            .req_size    (req_size),
            .req_signed  (req_signed),
            .req_addr    (req_addr),
            .req_wdata   (req_wdata),
            .resp_valid  (resp_valid[g]),
            .resp_rdata  (resp_rdata[g]),
            .resp_err    (resp_err[g]),
            .address     (address[g]),
            .read        (read[g]),
            .write       (write[g]),
            .byteenable  (byteenable[g]),
            .writedata   (writedata[g]),
            .waitrequest (waitrequest[g]),
            .readdata    (readdata)
        );
    end

    // Transaction currently being modelled; c counts edges since acceptance.
    int          sel;
    bit          active;
    bit          chk_en;
    int          c;
    bit          t_wr;
    bit          t_mis;
    logic [1:0]  t_sz;
    logic [31:0] t_addr;
    logic [31:0] t_wd;
    logic [31:0] t_exp;
    int          t_stalls;
    int          t_resp;
    logic [31:0] last_rdata [3];

    int          strobe_cnt;
    int          resp_at;
    logic [3:0]  seen_be;
    logic [31:0] seen_wd;
    logic [31:0] seen_addr;
    logic        seen_err;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic int lat_of(input int inst);
        return (inst == 0) ? 0 : ((inst == 1) ? 1 : 3);
    endfunction

    function automatic bit m_mis(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd0) return 1'b0;
        if (sz == 2'd1) return a[0];
        return (a % 4) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd0) return 4'(1 << (a % 4));
        if (sz == 2'd1) return ((a % 4) >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] wd);
        if (sz == 2'd0) return (wd & 32'hFF) * 32'h01010101;
        if (sz == 2'd1) return (wd & 32'hFFFF) * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] m_rd(input logic [1:0] sz, input bit sg,
                                         input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (rd >> (8 * (a % 4))) & 32'hFF;
            if (sg && v >= 32'h80) v = v | 32'hFFFFFF00;
        end else if (sz == 2'd1) begin
            v = (rd >> (16 * ((a % 4) / 2))) & 32'hFFFF;
            if (sg && v >= 32'h8000) v = v | 32'hFFFF0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    task automatic run_txn(input int inst, input bit wr, input logic [1:0] sz, input bit sg,
                           input logic [31:0] ad, input logic [31:0] wd, input logic [31:0] rd,
                           input int stalls);
        sel      = inst;
        t_wr     = wr;
        t_sz     = sz;
        t_addr   = ad;
        t_wd     = wd;
        t_stalls = stalls;
        t_mis    = m_mis(sz, ad);
        t_resp   = t_mis ? 0 : (wr ? stalls + 1 : stalls + 1 + lat_of(inst));
        t_exp    = (t_mis || wr) ? 32'd0 : m_rd(sz, sg, ad, rd);
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = ad;
        req_wdata  = wd;
        req_valid[inst] = 1'b1;
        @(posedge clk); #1;
        req_valid[inst] = 1'b0;
        req_write  = 1'($urandom);
        req_size   = 2'($urandom);
        req_signed = 1'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        active = 1'b1;
        c = 0;
        while (c <= t_resp) begin
            waitrequest[inst] = !t_mis && (c < stalls);
            readdata = (c == stalls + lat_of(inst)) ? rd : $urandom;
            @(posedge clk); #1;
            c++;
        end
        waitrequest[inst] = 1'b0;
        last_rdata[inst] = t_exp;
        active = 1'b0;
    endtask

    int  ci;
    bit  exp_strobe;

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                ci = sel;
                if (!active) begin
                    check("ready_idle", 32'(req_ready[ci]), 32'd1);
                    check("strobe_idle", 32'(read[ci] | write[ci]), 32'd0);
                    check("resp_valid_idle", 32'(resp_valid[ci]), 32'd0);
                    check("resp_rdata_hold", resp_rdata[ci], last_rdata[ci]);
                    strobe_cnt = 0;
                    resp_at    = -1;
                    seen_be    = 4'd0;
                    seen_wd    = 32'd0;
                    seen_addr  = 32'd0;
                    seen_err   = 1'b0;
                end else begin
                    exp_strobe = !t_mis && (c <= t_stalls);
                    check("ready_busy", 32'(req_ready[ci]), 32'd0);
                    check("read", 32'(read[ci]), 32'(exp_strobe && !t_wr));
                    check("write", 32'(write[ci]), 32'(exp_strobe && t_wr));
                    if (exp_strobe) begin
                        check("address", address[ci], t_addr & 32'hFFFFFFFC);
                        check("byteenable", 32'(byteenable[ci]), 32'(m_be(t_sz, t_addr)));
                        if (t_wr) check("writedata", writedata[ci], m_wd(t_sz, t_wd));
                    end
                    check("resp_valid", 32'(resp_valid[ci]), 32'(c == t_resp));
                    if (c == t_resp) begin
                        check("resp_rdata", resp_rdata[ci], t_exp);
                        check("resp_err", 32'(resp_err[ci]), 32'(t_mis));
                    end
                    if (read[ci] || write[ci]) begin
                        strobe_cnt++;
                        seen_be   = byteenable[ci];
                        seen_wd   = writedata[ci];
                        seen_addr = address[ci];
                    end
                    if (resp_valid[ci]) begin
                        resp_at  = c;
                        seen_err = resp_err[ci];
                    end
                end
            end
        end
    end

    logic [31:0] r_addr;

    initial begin
        reset_n = 1'b0;
        chk_en  = 1'b0;
        active  = 1'b0;
        sel     = 0;
        c       = 0;
        req_write  = 1'b0;
        req_size   = 2'd0;
        req_signed = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        readdata   = 32'd0;
        for (int i = 0; i < 3; i++) begin
            req_valid[i]   = 1'b0;
            waitrequest[i] = 1'b0;
            last_rdata[i]  = 32'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("rst_ready", 32'(req_ready[i]), 32'd1);
            check("rst_strobes", 32'(read[i] | write[i]), 32'd0);
            check("rst_be", 32'(byteenable[i]), 32'd0);
            check("rst_address", address[i], 32'd0);
            check("rst_writedata", writedata[i], 32'd0);
            check("rst_resp_valid", 32'(resp_valid[i]), 32'd0);
            check("rst_resp_rdata", resp_rdata[i], 32'd0);
            check("rst_resp_err", 32'(resp_err[i]), 32'd0);
        end
        reset_n = 1'b1;
        chk_en  = 1'b1;
        @(posedge clk); #1;

        run_txn(1, 1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 32'd0, 0);
        check("t1_strobe_cycles", strobe_cnt, 1);
        check("t1_address", seen_addr, 32'h100);
        check("t1_be", 32'(seen_be), 32'hF);
        check("t1_wd", seen_wd, 32'hDEADBEEF);
        check("t1_resp_at", resp_at, 1);

        run_txn(1, 1'b0, 2'd0, 1'b1, 32'h103, 32'd0, 32'h80FFFFFF, 0);
        check("t2s_be", 32'(seen_be), 32'h8);
        check("t2s_rdata", resp_rdata[1], 32'hFFFFFF80);
        check("t2s_resp_at", resp_at, 2);
        run_txn(1, 1'b0, 2'd0, 1'b0, 32'h103, 32'd0, 32'h80FFFFFF, 0);
        check("t2u_rdata", resp_rdata[1], 32'h00000080);

        run_txn(1, 1'b1, 2'd1, 1'b0, 32'h0A, 32'h00001234, 32'd0, 3);
        check("t3_strobe_cycles", strobe_cnt, 4);
        check("t3_be", 32'(seen_be), 32'hC);
        check("t3_wd", seen_wd, 32'h12341234);
        check("t3_resp_at", resp_at, 4);

        run_txn(1, 1'b0, 2'd2, 1'b0, 32'h102, 32'd0, 32'h55AA55AA, 0);
        check("t4_strobe_cycles", strobe_cnt, 0);
        check("t4_resp_at", resp_at, 0);
        check("t4_err", 32'(seen_err), 32'd1);
        check("t4_rdata", resp_rdata[1], 32'd0);

        chk_en = 1'b0;
        sel = 1;
        req_write  = 1'b0;
        req_size   = 2'd2;
        req_signed = 1'b0;
        req_addr   = 32'h40;
        req_valid[1]   = 1'b1;
        waitrequest[1] = 1'b1;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(posedge clk); #1;
        check("t5_read_stalled", 32'(read[1]), 32'd1);
        #3;
        reset_n = 1'b0;
        #1;
        check("t5_read_async", 32'(read[1]), 32'd0);
        check("t5_write_async", 32'(write[1]), 32'd0);
        check("t5_resp_async", 32'(resp_valid[1]), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("t5_resp_in_reset", 32'(resp_valid[1]), 32'd0);
        end
        reset_n = 1'b1;
        waitrequest[1] = 1'b0;
        for (int i = 0; i < 3; i++) last_rdata[i] = 32'd0;
        check("t5_ready_after", 32'(req_ready[1]), 32'd1);
        chk_en = 1'b1;
        run_txn(1, 1'b0, 2'd2, 1'b0, 32'h44, 32'd0, 32'hCAFEF00D, 1);
        check("t5_next_load", resp_rdata[1], 32'hCAFEF00D);

        run_txn(0, 1'b0, 2'd2, 1'b0, 32'h200, 32'd0, 32'h11223344, 0);
        check("t6_lat0_a", resp_at, 1);
        run_txn(0, 1'b0, 2'd1, 1'b1, 32'h206, 32'd0, 32'h9ABC0000, 0);
        check("t6_lat0_b", resp_at, 1);
        check("t6_lat0_rdata", resp_rdata[0], 32'hFFFF9ABC);
        run_txn(2, 1'b0, 2'd2, 1'b0, 32'h300, 32'd0, 32'h01020304, 0);
        check("t6_lat3_a", resp_at, 4);
        run_txn(2, 1'b0, 2'd0, 1'b0, 32'h301, 32'd0, 32'hA5A5F0A5, 0);
        check("t6_lat3_b", resp_at, 4);
        check("t6_lat3_rdata", resp_rdata[2], 32'h000000F0);

        for (int n = 0; n < 60; n++) begin
            r_addr = $urandom;
            if ($urandom_range(0, 3) != 0) r_addr[1:0] = 2'b00;
            run_txn($urandom_range(0, 2), 1'($urandom), 2'($urandom), 1'($urandom),
                    r_addr, $urandom, $urandom, $urandom_range(0, 3));
        end

        @(posedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
